// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, forwarding sources from EX/MEM and
// MEM/WB, and the EX-side outputs that feed the ALU and downstream stages.
//   slave  : the stage itself (takes ID/forwarding signals, drives ex_*/stall_id)
//   master : whoever drives ID and forwarding (pipeline or testbench)
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic              id_use_imm;
  logic [2:0]        id_alu_op;
  logic [4:0]        id_shamt;
  logic              id_reg_write, id_mem_read, id_mem_write;
  logic              flush;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [DATA_W-1:0] wb_result;
  logic              stall_id;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_reg1, ex_reg2, ex_store_data;
  logic [2:0]        ex_operation;
  logic [4:0]        ex_shamt;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write, ex_mem_read, ex_mem_write;
  logic [CNT_W-1:0]  bubble_count;

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_alu_op, id_shamt, id_reg_write, id_mem_read,
           id_mem_write, flush, mem_reg_write, mem_rd_addr, mem_result,
           wb_reg_write, wb_rd_addr, wb_result,
    output stall_id, ex_valid, ex_reg1, ex_reg2, ex_store_data, ex_operation,
           ex_shamt, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
           bubble_count
  );

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_alu_op, id_shamt, id_reg_write, id_mem_read,
           id_mem_write, flush, mem_reg_write, mem_rd_addr, mem_result,
           wb_reg_write, wb_rd_addr, wb_result,
    input  stall_id, ex_valid, ex_reg1, ex_reg2, ex_store_data, ex_operation,
           ex_shamt, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
           bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous reset, active low
//   bus   id_ex_stage_if.slave: ID fields, flush, EX/MEM + MEM/WB forwarding
//         sources in; stall_id, forwarded ALU operands, controls and
//         bubble_count out.
// Register address 0 is hardwired zero: it never forwards and always reads 0.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] rs_val, rt_val, imm;
    logic              use_imm;
    logic [2:0]        op;
    logic [4:0]        shamt;
    logic              reg_write, mem_read, mem_write;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt;
  logic             hazard;

  // Regfile write-through: an operand read in the same cycle MEM/WB writes it
  // would otherwise capture the stale value.
  function automatic logic [DATA_W-1:0] bypass(input logic [REG_AW-1:0] a,
                                               input logic [DATA_W-1:0] v,
                                               input logic we,
                                               input logic [REG_AW-1:0] wa,
                                               input logic [DATA_W-1:0] wd);
    return (we && wa != '0 && wa == a) ? wd : v;
  endfunction

  // EX operand forwarding; the younger EX/MEM result beats MEM/WB.
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] a,
                                            input logic [DATA_W-1:0] v,
                                            input logic mwe,
                                            input logic [REG_AW-1:0] ma,
                                            input logic [DATA_W-1:0] md,
                                            input logic wwe,
                                            input logic [REG_AW-1:0] wa,
                                            input logic [DATA_W-1:0] wd);
    if (a == '0)              return '0;
    else if (mwe && ma == a)  return md;
    else if (wwe && wa == a)  return wd;
    else                      return v;
  endfunction

  // A load in EX cannot forward in time to the instruction in ID. rt only
  // matters when it feeds the ALU or is store data.
  always_comb begin
    hazard = ex_q.valid && ex_q.mem_read && bus.id_valid && ex_q.rd != '0 &&
             (ex_q.rd == bus.id_rs_addr ||
              (ex_q.rd == bus.id_rt_addr && (!bus.id_use_imm || bus.id_mem_write)));
  end

  assign bus.stall_id = hazard && !bus.flush;

  always_comb begin
    ex_d = '0;
    if (!(bus.flush || hazard)) begin
      ex_d.valid   = bus.id_valid;
      ex_d.rs      = bus.id_rs_addr;
      ex_d.rt      = bus.id_rt_addr;
      ex_d.rd      = bus.id_rd_addr;
      ex_d.rs_val  = bypass(bus.id_rs_addr, bus.id_rs_data, bus.wb_reg_write,
                            bus.wb_rd_addr, bus.wb_result);
      ex_d.rt_val  = bypass(bus.id_rt_addr, bus.id_rt_data, bus.wb_reg_write,
                            bus.wb_rd_addr, bus.wb_result);
      ex_d.imm     = bus.id_imm;
      ex_d.use_imm = bus.id_use_imm;
      ex_d.op      = bus.id_alu_op;
      ex_d.shamt   = bus.id_shamt;
      // An empty ID slot must not write anything downstream.
      if (bus.id_valid) begin
        ex_d.reg_write = bus.id_reg_write;
        ex_d.mem_read  = bus.id_mem_read;
        ex_d.mem_write = bus.id_mem_write;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      cnt  <= '0;
    end else begin
      ex_q <= ex_d;
      // Only stall bubbles are counted; flush bubbles are branch cost.
      if (bus.stall_id && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  logic [DATA_W-1:0] rt_fwd;
  assign rt_fwd = fwd(ex_q.rt, ex_q.rt_val, bus.mem_reg_write, bus.mem_rd_addr,
                      bus.mem_result, bus.wb_reg_write, bus.wb_rd_addr, bus.wb_result);

  assign bus.ex_reg1       = fwd(ex_q.rs, ex_q.rs_val, bus.mem_reg_write, bus.mem_rd_addr,
                                 bus.mem_result, bus.wb_reg_write, bus.wb_rd_addr,
                                 bus.wb_result);
  assign bus.ex_reg2       = ex_q.use_imm ? ex_q.imm : rt_fwd;
  assign bus.ex_store_data = rt_fwd;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_operation  = ex_q.op;
  assign bus.ex_shamt      = ex_q.shamt;
  assign bus.ex_rd_addr    = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.bubble_count  = cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reset check, table of forwarding/bypass vectors,
// hand-written hazard/flush/reset sequences, then random traffic compared
// against an instruction-level reference model.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus();
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clr_all();
    bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
    bus.id_alu_op = 0; bus.id_shamt = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.id_mem_write = 0; bus.flush = 0; bus.mem_reg_write = 0; bus.mem_rd_addr = 0;
    bus.mem_result = 0; bus.wb_reg_write = 0; bus.wb_rd_addr = 0; bus.wb_result = 0;
  endtask

  task automatic id_load_r5();
    bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_mem_write = 0;
    bus.id_rd_addr = 5; bus.id_rs_addr = 1; bus.id_rt_addr = 2; bus.id_use_imm = 1;
  endtask

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rs_d, rt_d, imm;
    logic        ui;
    logic        cwe; logic [4:0] crd; logic [31:0] cres;
    logic        mwe; logic [4:0] mrd; logic [31:0] mres;
    logic        wwe; logic [4:0] wrd; logic [31:0] wres;
    logic [31:0] e1, e2, esd;
  } vec_t;

  // ---- reference model: one record per instruction sitting in EX ----
  typedef struct {
    bit v; bit [4:0] rs, rt, rd; bit [31:0] rsv, rtv, imm;
    bit ui; bit [2:0] op; bit [4:0] sh; bit rw, mr, mw;
  } mex_t;
  mex_t m;
  int   mcnt;

  function automatic bit [31:0] m_read(bit [4:0] a, bit [31:0] v);
    if (a == 0) return 0;
    if (bus.mem_reg_write && bus.mem_rd_addr == a) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd_addr == a) return bus.wb_result;
    return v;
  endfunction

  function automatic bit m_needs_wait();
    bit rt_used = !bus.id_use_imm || bus.id_mem_write;
    return m.v && m.mr && bus.id_valid && m.rd != 0 &&
           (m.rd == bus.id_rs_addr || (rt_used && m.rd == bus.id_rt_addr));
  endfunction

  function automatic bit [31:0] m_regfile(bit [4:0] a, bit [31:0] v);
    return (bus.wb_reg_write && bus.wb_rd_addr != 0 && bus.wb_rd_addr == a) ? bus.wb_result : v;
  endfunction

  vec_t vt[8];

  initial begin
    bit hold;
    bit wait_now;
    // ---------- reset with nonzero inputs ----------
    bus.id_valid = 1; bus.id_rs_addr = 3; bus.id_rt_addr = 4; bus.id_rd_addr = 6;
    bus.id_rs_data = 32'hAAAA; bus.id_rt_data = 32'hBBBB; bus.id_imm = 32'h7;
    bus.id_use_imm = 0; bus.id_alu_op = 3'd2; bus.id_shamt = 5'd9; bus.id_reg_write = 1;
    bus.id_mem_read = 1; bus.id_mem_write = 1; bus.flush = 0; bus.mem_reg_write = 1;
    bus.mem_rd_addr = 3; bus.mem_result = 32'h1234; bus.wb_reg_write = 1;
    bus.wb_rd_addr = 4; bus.wb_result = 32'h5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_stall", bus.stall_id, 0);
    chk("rst_count", bus.bubble_count, 0);
    chk("rst_reg1", bus.ex_reg1, 0);
    chk("rst_reg2_sd", {bus.ex_reg2, bus.ex_store_data}, 0);
    chk("rst_ctrl", {bus.ex_operation, bus.ex_shamt, bus.ex_rd_addr, bus.ex_reg_write,
                     bus.ex_mem_read, bus.ex_mem_write}, 0);
    clr_all();
    rst_n = 1;
    @(posedge clk); #1;

    // ---------- forwarding / write-through table ----------
    //        rs rt rs_d          rt_d          imm    ui cwe crd cres        mwe mrd mres          wwe wrd wres          e1            e2            esd
    vt[0] = '{3, 6, 32'h1,        32'h66,       32'h0, 0, 0, 0, 32'h0,       1, 3, 32'h11,         1, 3, 32'h22,         32'h11,       32'h66,       32'h66};
    vt[1] = '{3, 6, 32'h1,        32'h66,       32'h0, 0, 0, 0, 32'h0,       0, 3, 32'h11,         1, 3, 32'h22,         32'h22,       32'h66,       32'h66};
    vt[2] = '{0, 0, 32'h99,       32'h98,       32'h0, 0, 1, 0, 32'h1,       1, 0, 32'hFFFF_FFFF,  1, 0, 32'hEEEE_EEEE,  32'h0,        32'h0,        32'h0};
    vt[3] = '{1, 7, 32'hA,        32'h0,        32'h0, 0, 1, 7, 32'h55,      0, 0, 32'h0,          0, 0, 32'h0,          32'hA,        32'h55,       32'h55};
    vt[4] = '{1, 7, 32'hA,        32'h0,        32'h10,1, 1, 7, 32'h55,      0, 0, 32'h0,          0, 0, 32'h0,          32'hA,        32'h10,       32'h55};
    vt[5] = '{2, 4, 32'h1234,     32'h5678,     32'h0, 0, 0, 0, 32'h0,       1, 9, 32'hDEAD,       1,10, 32'hBEEF,       32'h1234,     32'h5678,     32'h5678};
    vt[6] = '{2, 4, 32'h1,        32'h5,        32'h0, 0, 0, 0, 32'h0,       0, 4, 32'h99,         1, 4, 32'h77,         32'h1,        32'h77,       32'h77};
    vt[7] = '{4, 4, 32'h3,        32'h5,        32'h0, 0, 0, 0, 32'h0,       1, 4, 32'h99,         1, 4, 32'h77,         32'h99,       32'h99,       32'h99};
    for (int i = 0; i < 8; i++) begin
      clr_all();
      bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rd_addr = 1;
      bus.id_rs_addr = vt[i].rs; bus.id_rt_addr = vt[i].rt;
      bus.id_rs_data = vt[i].rs_d; bus.id_rt_data = vt[i].rt_d;
      bus.id_imm = vt[i].imm; bus.id_use_imm = vt[i].ui;
      bus.wb_reg_write = vt[i].cwe; bus.wb_rd_addr = vt[i].crd; bus.wb_result = vt[i].cres;
      @(posedge clk); #1;
      clr_all();
      bus.mem_reg_write = vt[i].mwe; bus.mem_rd_addr = vt[i].mrd; bus.mem_result = vt[i].mres;
      bus.wb_reg_write = vt[i].wwe; bus.wb_rd_addr = vt[i].wrd; bus.wb_result = vt[i].wres;
      @(negedge clk);
      chk($sformatf("vec%0d_reg1", i), bus.ex_reg1, vt[i].e1);
      chk($sformatf("vec%0d_reg2", i), bus.ex_reg2, vt[i].e2);
      chk($sformatf("vec%0d_store", i), bus.ex_store_data, vt[i].esd);
      @(posedge clk); #1;
    end

    // ---------- load-use stall ----------
    clr_all(); id_load_r5();
    @(posedge clk); #1;
    clr_all();
    bus.id_valid = 1; bus.id_rs_addr = 5; bus.id_rt_addr = 6; bus.id_rd_addr = 8;
    bus.id_rs_data = 32'h42; bus.id_reg_write = 1;
    @(negedge clk);
    chk("lu_stall_on", bus.stall_id, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lu_stall_off", bus.stall_id, 0);
    chk("lu_bubble_valid", bus.ex_valid, 0);
    chk("lu_bubble_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 0);
    chk("lu_count1", bus.bubble_count, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lu_cap_valid", bus.ex_valid, 1);
    chk("lu_cap_rd", bus.ex_rd_addr, 8);
    chk("lu_cap_reg1", bus.ex_reg1, 32'h42);
    chk("lu_cap_count", bus.bubble_count, 1);
    @(posedge clk); #1;

    // ---------- load-use with flush ----------
    clr_all(); id_load_r5();
    @(posedge clk); #1;
    clr_all();
    bus.id_valid = 1; bus.id_rs_addr = 5; bus.id_rd_addr = 8; bus.id_reg_write = 1;
    bus.flush = 1;
    @(negedge clk);
    chk("fl_stall", bus.stall_id, 0);
    @(posedge clk); #1;
    clr_all();
    @(negedge clk);
    chk("fl_valid", bus.ex_valid, 0);
    chk("fl_count", bus.bubble_count, 1);

    // ---------- rt hazard rules, then reset mid-stall ----------
    @(posedge clk); #1;
    clr_all(); id_load_r5();
    @(posedge clk); #1;
    clr_all();
    bus.id_valid = 1; bus.id_rs_addr = 1; bus.id_rt_addr = 5; bus.id_use_imm = 1;
    @(negedge clk);
    chk("rt_imm_nostall", bus.stall_id, 0);
    bus.id_mem_write = 1;
    #1;
    chk("rt_store_stall", bus.stall_id, 1);
    rst_n = 0;
    #1;
    chk("rstmid_stall", bus.stall_id, 0);
    chk("rstmid_count", bus.bubble_count, 0);
    chk("rstmid_valid", bus.ex_valid, 0);
    @(negedge clk);
    clr_all();
    rst_n = 1;

    // ---------- random traffic vs reference model ----------
    m = '{default: '0};
    mcnt = 0;
    hold = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        bus.id_valid     = ($urandom_range(4) != 0);
        bus.id_rs_addr   = 5'($urandom_range(7));
        bus.id_rt_addr   = 5'($urandom_range(7));
        bus.id_rd_addr   = 5'($urandom_range(7));
        bus.id_rs_data   = $urandom;
        bus.id_rt_data   = $urandom;
        bus.id_imm       = $urandom;
        bus.id_use_imm   = 1'($urandom_range(1));
        bus.id_alu_op    = 3'($urandom_range(6));
        bus.id_shamt     = 5'($urandom);
        bus.id_reg_write = 1'($urandom_range(1));
        bus.id_mem_read  = ($urandom_range(2) == 0);
        bus.id_mem_write = ($urandom_range(3) == 0);
      end
      bus.flush         = ($urandom_range(9) == 0);
      bus.mem_reg_write = 1'($urandom_range(1));
      bus.mem_rd_addr   = 5'($urandom_range(7));
      bus.mem_result    = $urandom;
      bus.wb_reg_write  = 1'($urandom_range(1));
      bus.wb_rd_addr    = 5'($urandom_range(7));
      bus.wb_result     = $urandom;
      @(negedge clk);
      wait_now = m_needs_wait() && !bus.flush;
      chk("rnd_stall", bus.stall_id, wait_now);
      chk("rnd_valid", bus.ex_valid, m.v);
      chk("rnd_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, {m.rw, m.mr, m.mw});
      chk("rnd_count", bus.bubble_count, mcnt);
      if (m.v) begin
        chk("rnd_reg1", bus.ex_reg1, m_read(m.rs, m.rsv));
        chk("rnd_reg2", bus.ex_reg2, m.ui ? m.imm : m_read(m.rt, m.rtv));
        chk("rnd_store", bus.ex_store_data, m_read(m.rt, m.rtv));
        chk("rnd_fields", {bus.ex_operation, bus.ex_shamt, bus.ex_rd_addr}, {m.op, m.sh, m.rd});
      end
      hold = wait_now;
      @(posedge clk);
      if (bus.flush || m_needs_wait()) begin
        m = '{default: '0};
      end else begin
        m.v   = bus.id_valid;
        m.rs  = bus.id_rs_addr;  m.rt = bus.id_rt_addr; m.rd = bus.id_rd_addr;
        m.rsv = m_regfile(bus.id_rs_addr, bus.id_rs_data);
        m.rtv = m_regfile(bus.id_rt_addr, bus.id_rt_data);
        m.imm = bus.id_imm; m.ui = bus.id_use_imm; m.op = bus.id_alu_op; m.sh = bus.id_shamt;
        m.rw  = bus.id_valid && bus.id_reg_write;
        m.mr  = bus.id_valid && bus.id_mem_read;
        m.mw  = bus.id_valid && bus.id_mem_write;
      end
      if (wait_now && mcnt < 65535) mcnt++;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
